fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/fetch_queue.sv | 40 ++++
 rtl/fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage types and defaults
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef logic [XLEN-1:0] word_t;
    typedef enum logic [1:0] {FETCH, FULL, DRAIN} fetch_state_t;
    typedef struct packed {
        word_t pc;
        word_t inst;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc, inst} entries with clear
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fq_entry_t              din,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fq_entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = count != '0 ? mem[rd] : '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (clear) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with redirect draining and an instruction queue
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_pc,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t state, state_nxt;
    word_t fetch_pc, rsp_pc;
    logic [CW-1:0] live, drop, q_count, pending, drop_flush, live_nxt, drop_nxt, q_nxt;
    logic accept, live_rsp, push, pop;
    fq_entry_t head, rsp;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (rsp),
        .head  (head),
        .count (q_count)
    );

    // live requests are consecutive words, so the oldest one sits live*4 behind fetch_pc
    assign rsp_pc     = fetch_pc - (word_t'(live) << 2);
    assign rsp        = {rsp_pc, imem_rdata};
    assign imem_addr  = fetch_pc;
    assign inst_valid = q_count != '0;
    assign inst_out   = head.inst;
    assign pc_out     = head.pc;

    always_comb begin
        pending    = live + drop;
        imem_req   = rst && state == FETCH && q_count + live < CW'(DEPTH) && !flush;
        accept     = imem_req && imem_ready;
        live_rsp   = imem_rvalid && drop == '0 && live != '0;
        push       = live_rsp && !flush;
        pop        = inst_valid && !hold_pc && !flush;
        drop_flush = pending - CW'(imem_rvalid && pending != '0);
        live_nxt   = live + CW'(accept) - CW'(live_rsp);
        drop_nxt   = drop - CW'(imem_rvalid && drop != '0);
        q_nxt      = q_count + CW'(push) - CW'(pop);
        state_nxt  = flush ? (drop_flush != '0 ? DRAIN : FETCH)
                   : state == DRAIN ? (drop_nxt == '0 ? FETCH : DRAIN)
                   : q_nxt + live_nxt == CW'(DEPTH) ? FULL : FETCH;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            live     <= '0;
            drop     <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= flush ? redirect_pc & ~32'd3 : fetch_pc + (accept ? 32'd4 : 32'd0);
            live     <= flush ? '0 : live_nxt;
            drop     <= flush ? drop_flush : drop_nxt;
        end
endmodule
